// File: rtl/pci_dp_pkg.sv
// Shared definitions for the PCI data-phase target: state codes, default
// deadline and the wait-counter width helper.
package pci_dp_pkg;

    typedef logic [2:0] dp_state_t;

    localparam dp_state_t ST_IDLE = 3'd0;
    localparam dp_state_t ST_WAIT = 3'd1;
    localparam dp_state_t ST_XFER = 3'd2;
    localparam dp_state_t ST_STOP = 3'd3;
    localparam dp_state_t ST_TURN = 3'd4;

    localparam int DP_MAX_WAIT_DEF = 5;

    function automatic int dp_cnt_w(input int max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/pci_dp_target_dp_wait_timer.sv
// Wait-edge counter: the rise edge is wait edge 1, each later WAIT edge
// adds one, and deadline flags the edge whose number equals MAX_WAIT.
module dp_wait_timer
    import pci_dp_pkg::*;
#(
    parameter int MAX_WAIT = DP_MAX_WAIT_DEF
) (
    input  logic mclk,
    input  logic rst_n,
    input  logic start,
    input  logic run,
    output logic deadline
);

    localparam int W = dp_cnt_w(MAX_WAIT);

    logic [W-1:0] cnt;
    logic [W-1:0] cur;

    // cur is the number of the wait edge being evaluated right now
    assign cur      = start ? W'(1) : cnt + W'(1);
    assign deadline = (cur == W'(MAX_WAIT));

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= W'(1);
        end else if (run) begin
            cnt <= cur;
        end
    end

endmodule

// File: rtl/pci_dp_target.sv
// Target-side data-phase responder: answers each data phase with trdy when
// backend data arrives in time, otherwise with a stop/retry before the deadline.
module pci_dp_target
    import pci_dp_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = DP_MAX_WAIT_DEF
) (
    input  logic              mclk,
    input  logic              rst_n,
    input  logic              data_phase,
    input  logic              irdy,
    output logic              trdy,
    output logic              stop,
    output logic [DATA_W-1:0] ad_out,
    output logic              ad_oe,
    output logic              be_req,
    input  logic              be_ready,
    input  logic [DATA_W-1:0] be_rdata,
    output logic              irdy_late,
    output logic [7:0]        retry_cnt
);

    dp_state_t state;
    logic      dp_q;
    logic      rise;
    logic      start;
    logic      run;
    logic      wait_edge;
    logic      accept;
    logic      deadline;
    logic      timeout;

    // The rise edge itself already counts as the first wait edge, so a ready
    // backend can be answered with trdy on the very next clock.
    assign rise      = data_phase & ~dp_q;
    assign start     = (state == ST_IDLE) & rise;
    assign run       = (state == ST_WAIT) & data_phase;
    assign wait_edge = start | run;
    assign accept    = wait_edge & be_ready & ~irdy;
    assign timeout   = wait_edge & deadline & ~accept;

    dp_wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_timer (
        .mclk    (mclk),
        .rst_n   (rst_n),
        .start   (start),
        .run     (run),
        .deadline(deadline)
    );

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            dp_q      <= 1'b0;
            trdy      <= 1'b1;
            stop      <= 1'b1;
            ad_out    <= '0;
            ad_oe     <= 1'b0;
            be_req    <= 1'b0;
            irdy_late <= 1'b0;
            retry_cnt <= 8'd0;
        end else begin
            dp_q      <= data_phase;
            be_req    <= start;
            irdy_late <= 1'b0;
            case (state)
                ST_IDLE, ST_WAIT: begin
                    if (accept) begin
                        trdy   <= 1'b0;
                        ad_out <= be_rdata;
                        ad_oe  <= 1'b1;
                        state  <= ST_XFER;
                    end else if (timeout) begin
                        stop      <= 1'b0;
                        irdy_late <= irdy;
                        state     <= ST_STOP;
                        if (retry_cnt != 8'hFF) begin
                            retry_cnt <= retry_cnt + 8'd1;
                        end
                    end else if (start) begin
                        state <= ST_WAIT;
                    end else if ((state == ST_WAIT) && !data_phase) begin
                        state <= ST_IDLE;
                    end
                end
                ST_XFER: begin
                    trdy  <= 1'b1;
                    ad_oe <= 1'b0;
                    state <= ST_TURN;
                end
                // Retry is held until the initiator closes the data phase
                ST_STOP: begin
                    if (!data_phase) begin
                        stop  <= 1'b1;
                        state <= ST_TURN;
                    end
                end
                ST_TURN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pci_dp_target.sv
// Self-checking bench for pci_dp_target: directed vector table, random data
// phases against a transaction-level model, saturation and reset sequences,
// plus a concurrent data-end window and trdy/stop exclusion monitor.
module tb_pci_dp_target;

    localparam int MAX_WAIT = 5;
    localparam int D        = MAX_WAIT - 1;
    localparam int K_XFER   = 0;
    localparam int K_STOP   = 1;
    localparam int K_ABORT  = 2;

    logic        mclk;
    logic        rst_n;
    logic        data_phase;
    logic        irdy;
    logic        trdy;
    logic        stop;
    logic [31:0] ad_out;
    logic        ad_oe;
    logic        be_req;
    logic        be_ready;
    logic [31:0] be_rdata;
    logic        irdy_late;
    logic [7:0]  retry_cnt;

    int          n_cmp;
    int          n_bad;
    logic [7:0]  exp_retry;

    typedef struct {
        logic [4:0]  rdy;
        logic [4:0]  ird;
        logic [31:0] rd;
        int          ab;
        int          hold;
        int          kind;
        int          k;
        logic        late;
    } vec_t;

    vec_t tbl[11];

    pci_dp_target #(
        .DATA_W  (32),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .mclk      (mclk),
        .rst_n     (rst_n),
        .data_phase(data_phase),
        .irdy      (irdy),
        .trdy      (trdy),
        .stop      (stop),
        .ad_out    (ad_out),
        .ad_oe     (ad_oe),
        .be_req    (be_req),
        .be_ready  (be_ready),
        .be_rdata  (be_rdata),
        .irdy_late (irdy_late),
        .retry_cnt (retry_cnt)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Outcome of one data phase derived from the rules: walk the wait edges,
    // abort beats everything, a ready+irdy-low edge wins over the deadline.
    function automatic void classify(input logic [4:0] rdy, input logic [4:0] ird, input int ab,
                                     output int kind, output int k, output logic late);
        kind = K_ABORT;
        k    = 0;
        late = 1'b0;
        for (int m = 0; m <= D; m++) begin
            if (ab != 0 && m == ab) begin
                kind = K_ABORT;
                return;
            end
            if (rdy[m[2:0]] && !ird[m[2:0]]) begin
                kind = K_XFER;
                k    = m;
                return;
            end
            if (m == D) begin
                kind = K_STOP;
                late = ird[m[2:0]];
                return;
            end
        end
    endfunction

    // Drives one data phase starting at a negedge with the target idle, and
    // checks every output after each edge t0+m.
    task automatic apply_stimulus(input logic [4:0] rdy, input logic [4:0] ird, input logic [31:0] rd,
                                  input int ab, input int hold, input int kind, input int k,
                                  input logic late);
        int         fin;
        logic [7:0] base;
        logic [7:0] after;
        logic [4:0] rdy_sh;
        logic [4:0] ird_sh;
        logic       trdy_e;
        logic       stop_e;
        logic       late_e;
        fin    = (kind == K_XFER) ? k + 1 : (kind == K_STOP) ? D + hold + 1 : ab;
        base   = exp_retry;
        after  = (kind == K_STOP && base != 8'hFF) ? base + 8'd1 : base;
        rdy_sh = rdy;
        ird_sh = ird;
        for (int m = 0; m <= fin + 2; m++) begin
            data_phase = (m < fin);
            be_ready   = rdy_sh[0];
            irdy       = ird_sh[0];
            be_rdata   = rd;
            rdy_sh     = rdy_sh >> 1;
            ird_sh     = ird_sh >> 1;
            @(posedge mclk);
            @(negedge mclk);
            trdy_e = !(kind == K_XFER && m == k);
            stop_e = !(kind == K_STOP && m >= D && m < fin);
            late_e = (kind == K_STOP && m == D && late);
            check_output("trdy", trdy, trdy_e);
            check_output("stop", stop, stop_e);
            check_output("ad_oe", ad_oe, !trdy_e);
            check_output("be_req", be_req, m == 0);
            check_output("irdy_late", irdy_late, late_e);
            check_output("retry_cnt", retry_cnt, (kind == K_STOP && m >= D) ? after : base);
            if (!trdy_e) begin
                check_output("ad_out", ad_out, rd);
            end
        end
        exp_retry = after;
    endtask

    // Concurrent data-end monitor: after a rise, trdy or stop must be seen
    // low within 1..MAX_WAIT clocks unless the initiator drops the phase.
    initial begin
        bit armed;
        bit prev_dp;
        int win;
        armed   = 0;
        prev_dp = 0;
        win     = 0;
        forever begin
            @(posedge mclk);
            #1;
            if (!rst_n) begin
                armed   = 0;
                prev_dp = 0;
            end else begin
                n_cmp++;
                if (!trdy && !stop) begin
                    n_bad++;
                    $display("[TB] FAIL exclusion: trdy=%b stop=%b, want not both 0 at %0t", trdy, stop, $time);
                end
                if (!armed && data_phase && !prev_dp) begin
                    armed = 1;
                    win   = 0;
                end
                if (armed) begin
                    win++;
                    if (!trdy || !stop) begin
                        armed = 0;
                        check_output("data_end_window", win, (win >= 1 && win <= MAX_WAIT) ? win : 0);
                    end else if (!data_phase) begin
                        armed = 0;
                    end else if (win >= MAX_WAIT) begin
                        armed = 0;
                        n_cmp++;
                        n_bad++;
                        $display("[TB] FAIL data_end: no trdy/stop after %0d clocks, want <= %0d at %0t", win, MAX_WAIT, $time);
                    end
                end
                prev_dp = data_phase;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         kind;
        int         k;
        logic       late;
        logic [4:0] rdy;
        logic [4:0] ird;
        int         ab;

        n_cmp      = 0;
        n_bad      = 0;
        exp_retry  = 8'd0;
        rst_n      = 1'b0;
        data_phase = 1'b0;
        irdy       = 1'b1;
        be_ready   = 1'b0;
        be_rdata   = 32'd0;

        tbl[0]  = '{5'b00001, 5'b00000, 32'hCAFE_0001, 0, 0, K_XFER, 0, 1'b0};
        tbl[1]  = '{5'b00000, 5'b00000, 32'h1111_2222, 0, 3, K_STOP, 0, 1'b0};
        tbl[2]  = '{5'b10000, 5'b00000, 32'h0BAD_F00D, 0, 0, K_XFER, 4, 1'b0};
        tbl[3]  = '{5'b00000, 5'b11111, 32'h3333_4444, 0, 0, K_STOP, 0, 1'b1};
        tbl[4]  = '{5'b00000, 5'b00000, 32'h5555_6666, 2, 0, K_ABORT, 0, 1'b0};
        tbl[5]  = '{5'b00110, 5'b00011, 32'hA5A5_5A5A, 0, 0, K_XFER, 2, 1'b0};
        tbl[6]  = '{5'b00000, 5'b01111, 32'h7777_8888, 0, 1, K_STOP, 0, 1'b0};
        tbl[7]  = '{5'b10000, 5'b10000, 32'h9999_AAAA, 0, 2, K_STOP, 0, 1'b1};
        tbl[8]  = '{5'b01000, 5'b00000, 32'hBBBB_CCCC, 1, 0, K_ABORT, 0, 1'b0};
        tbl[9]  = '{5'b01000, 5'b00000, 32'hDEAD_BEEF, 4, 0, K_XFER, 3, 1'b0};
        tbl[10] = '{5'b00000, 5'b00000, 32'hEEEE_FFFF, 4, 0, K_ABORT, 0, 1'b0};

        repeat (2) @(negedge mclk);
        check_output("reset_trdy", trdy, 1'b1);
        check_output("reset_stop", stop, 1'b1);
        check_output("reset_ad_out", ad_out, 32'd0);
        check_output("reset_ad_oe", ad_oe, 1'b0);
        check_output("reset_be_req", be_req, 1'b0);
        check_output("reset_irdy_late", irdy_late, 1'b0);
        check_output("reset_retry_cnt", retry_cnt, 8'd0);
        rst_n = 1'b1;
        @(negedge mclk);

        $display("[TB] directed vector table");
        for (int i = 0; i < 11; i++) begin
            apply_stimulus(tbl[i].rdy, tbl[i].ird, tbl[i].rd, tbl[i].ab, tbl[i].hold,
                           tbl[i].kind, tbl[i].k, tbl[i].late);
        end

        $display("[TB] random data phases");
        for (int i = 0; i < 40; i++) begin
            rdy = 5'($urandom);
            ird = 5'($urandom) & 5'($urandom);
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, D)) : 0;
            classify(rdy, ird, ab, kind, k, late);
            apply_stimulus(rdy, ird, $urandom, ab, int'($urandom_range(0, 3)), kind, k, late);
        end

        $display("[TB] retry counter saturation");
        for (int i = 0; i < 260; i++) begin
            apply_stimulus(5'b00000, 5'b11111, 32'd0, 0, 0, K_STOP, 0, 1'b1);
        end
        check_output("retry_saturated", retry_cnt, 8'hFF);

        $display("[TB] reset while stop is asserted");
        data_phase = 1'b1;
        be_ready   = 1'b0;
        irdy       = 1'b0;
        for (int m = 0; m <= D; m++) begin
            @(posedge mclk);
            @(negedge mclk);
        end
        check_output("stop_before_reset", stop, 1'b0);
        rst_n = 1'b0;
        #1;
        check_output("midreset_stop", stop, 1'b1);
        check_output("midreset_trdy", trdy, 1'b1);
        check_output("midreset_retry_cnt", retry_cnt, 8'd0);
        check_output("midreset_irdy_late", irdy_late, 1'b0);
        data_phase = 1'b0;
        @(negedge mclk);
        rst_n     = 1'b1;
        exp_retry = 8'd0;
        @(negedge mclk);
        apply_stimulus(5'b00001, 5'b00000, 32'h1234_5678, 0, 0, K_XFER, 0, 1'b0);
        apply_stimulus(5'b00000, 5'b00000, 32'd0, 0, 1, K_STOP, 0, 1'b0);

        repeat (2) @(negedge mclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
